// File: rtl/algo_refr_pkg.sv
// Shared types and helpers for the a24 refresh scheduler.
// Typedef widths describe the default family configuration (2 banks bits, 8 row bits, 3 credit bits).
package algo_refr_pkg;

    localparam int unsigned RefrMaxRdPt = 16;
    localparam int unsigned RefrBankW   = 2;
    localparam int unsigned RefrRowW    = 8;
    localparam int unsigned RefrCredW   = 3;
    localparam int unsigned RefrPerW    = 16;

    typedef logic [RefrBankW-1:0] refr_bank_t;
    typedef logic [RefrRowW-1:0]  refr_row_t;
    typedef logic [RefrCredW-1:0] refr_cred_t;

    typedef struct packed {
        logic       vld;
        refr_bank_t bank;
        refr_row_t  row;
    } refr_cmd_t;

    // Half-cycle mode stretches every other interval by one cycle.
    function automatic logic [RefrPerW-1:0] refr_period(input logic [RefrPerW-1:0] freq,
                                                        input logic half, input logic phase);
        return (half && phase) ? freq + 16'd1 : freq;
    endfunction

    function automatic logic refr_conflict(input logic [RefrMaxRdPt-1:0] rd_hit,
                                           input logic wr_hit);
        return wr_hit || (|rd_hit);
    endfunction

endpackage

// File: rtl/algo_refr_interval.sv
// Refresh interval timer: counts 0..P-1 while enabled and pulses tick on P-1.
// With half-cycle mode the period alternates REFFREQ, REFFREQ+1.
module algo_refr_interval
    import algo_refr_pkg::*;
#(
    parameter int unsigned REFFREQ = 6,
    parameter int unsigned REFFRHF = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned TimerW = $clog2(REFFREQ + 2);

    logic [TimerW-1:0]   cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [RefrPerW-1:0] period;

    assign period = refr_period(RefrPerW'(REFFREQ), REFFRHF != 0, phase_q);
    assign tick_o = en_i && (RefrPerW'(cnt_q) == period - 16'd1);

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (en_i) begin
            if (tick_o) begin
                cnt_d   = '0;
                phase_d = (REFFRHF != 0) ? ~phase_q : 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/algo_nr1w_a24_refr_sched.sv
// Credit-based round-robin refresh scheduler for the a24 multi-read-port memory family.
// Define ALGO_REFR_FORCE_EN to force a refresh (and block the bank) when credit saturates.
module algo_nr1w_a24_refr_sched
    import algo_refr_pkg::*;
#(
    parameter int unsigned NUMRDPT = 2,
    parameter int unsigned NUMRBNK = 4,
    parameter int unsigned BITRBNK = 2,
    parameter int unsigned NUMRROW = 256,
    parameter int unsigned BITRROW = 8,
    parameter int unsigned REFFREQ = 6,
    parameter int unsigned REFFRHF = 0,
    parameter int unsigned MAXCRED = 4,
    parameter int unsigned BITCRED = 3,
    parameter int unsigned INITDLY = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       refr,
    input  logic [NUMRDPT-1:0]         rd_act,
    input  logic [NUMRDPT*BITRBNK-1:0] rd_bank,
    input  logic                       wr_act,
    input  logic [BITRBNK-1:0]         wr_bank,
    output logic                       ready,
    output logic                       blk_vld,
    output logic [BITRBNK-1:0]         blk_bank,
    output logic                       t1_refrC,
    output logic [BITRBNK-1:0]         t1_bankC,
    output logic [BITRROW-1:0]         t1_rowC,
    output logic                       err_ovf
);

    localparam int unsigned InitW = $clog2(INITDLY + 1);

    logic               rst_q;
    logic               rst_int;
    logic [InitW-1:0]   init_cnt_q, init_cnt_d;
    logic               ready_q, ready_d;
    logic [BITCRED-1:0] credit_q, credit_d;
    logic [BITRBNK-1:0] ptr_q, ptr_d;
    logic [BITRROW-1:0] row_q, row_d;
    logic               refr_q, refr_d;
    logic [BITRBNK-1:0] bank_q, bank_d;
    logic [BITRROW-1:0] rowc_q, rowc_d;
    logic               ovf_q, ovf_d;

    logic                   tick;
    logic [RefrMaxRdPt-1:0] rd_hit;
    logic                   wr_hit;
    logic                   conf;
    logic                   cred_max;
    logic                   cred_nz;
    logic                   normal_iss;
    logic                   force_iss;
    logic                   issue;

    // A lone one-cycle rst pulse is filtered out.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end
    assign rst_int = rst && rst_q;

    algo_refr_interval #(
        .REFFREQ (REFFREQ),
        .REFFRHF (REFFRHF)
    ) u_interval (
        .clk_i  (clk),
        .rst_i  (rst_int),
        .en_i   (ready_q),
        .tick_o (tick)
    );

    always_comb begin
        rd_hit = '0;
        for (int k = 0; k < NUMRDPT; k++) begin
            rd_hit[k] = rd_act[k] && (rd_bank[k*BITRBNK +: BITRBNK] == ptr_q);
        end
    end

    assign wr_hit     = wr_act && (wr_bank == ptr_q);
    assign conf       = refr_conflict(rd_hit, wr_hit);
    assign cred_max   = (credit_q == BITCRED'(MAXCRED));
    assign cred_nz    = (credit_q != '0);
    assign normal_iss = ready_q && cred_nz && refr && !conf;

`ifdef ALGO_REFR_FORCE_EN
    assign force_iss = ready_q && cred_max;
`else
    assign force_iss = 1'b0;
`endif

    assign issue = normal_iss || force_iss;

    // Decoded from state only so the core sees no combinational input path.
    assign blk_vld  = force_iss;
    assign blk_bank = force_iss ? ptr_q : '0;

    always_comb begin
        init_cnt_d = init_cnt_q;
        ready_d    = ready_q;
        if (!ready_q) begin
            if (init_cnt_q == InitW'(INITDLY - 1)) begin
                ready_d = 1'b1;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        credit_d = credit_q;
        ovf_d    = ovf_q;
        if (tick && !issue) begin
            if (cred_max) begin
                ovf_d = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end else if (!tick && issue) begin
            credit_d = credit_q - 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        row_d = row_q;
        if (issue) begin
            if (ptr_q == BITRBNK'(NUMRBNK - 1)) begin
                ptr_d = '0;
                row_d = (row_q == BITRROW'(NUMRROW - 1)) ? '0 : row_q + 1'b1;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_comb begin
        refr_d = issue;
        bank_d = issue ? ptr_q : '0;
        rowc_d = issue ? row_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst_int) begin
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            credit_q   <= '0;
            ptr_q      <= '0;
            row_q      <= '0;
            refr_q     <= 1'b0;
            bank_q     <= '0;
            rowc_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
            credit_q   <= credit_d;
            ptr_q      <= ptr_d;
            row_q      <= row_d;
            refr_q     <= refr_d;
            bank_q     <= bank_d;
            rowc_q     <= rowc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ready    = ready_q;
    assign t1_refrC = refr_q;
    assign t1_bankC = bank_q;
    assign t1_rowC  = rowc_q;
    assign err_ovf  = ovf_q;

endmodule
